s2mm_frame_scheduler: RTL and testbench
=======================================

// Module: s2mm_frame_scheduler
// PURPOSE
//  Sequences and configures the S2MM frame writer. Owns the writer's soft_resetn and enable/drain
//  handshake, and rotates the writer base address over 3..4 frame buffers (triple-buffering).
//  Lends the newest completed frame to one reader (VDMA/MM2S side) without it being overwritten.
//  Sits between the register file (enable, buffer addresses) and the writer's control ports.
// PARAMETERS
//  C_ADDR_WIDTH  32  width of buffer base addresses
//  C_BUF_NUM     3   number of frame buffers; legal values 3 or 4
//  C_IDX_WIDTH   2   width of buffer index ports
// PORTS
//  M_AXI_ACLK        in   1             sole clock; all logic rising-edge
//  M_AXI_ARESET      in   1             asynchronous, active-high reset
//  enable            in   1             software enable of the write path (level)
//  buf_addr0..3      in   C_ADDR_WIDTH  buffer base addresses; buf_addr3 unused when C_BUF_NUM=3
//  s2mm_soft_resetn  out  1             to writer soft_resetn
//  s2mm_resetting    in   1             from writer resetting
//  s2mm_frame_pulse  in   1             from writer frame_pulse (one cycle, new frame starting)
//  s2mm_base_addr    out  C_ADDR_WIDTH  to writer base_addr
//  wr_idx            out  C_IDX_WIDTH   buffer currently being written
//  rd_req            in   1             reader request for the newest frame (pulse)
//  rd_release        in   1             reader done with its locked buffer (pulse)
//  rd_grant          out  1             one-cycle grant pulse
//  rd_idx            out  C_IDX_WIDTH   locked buffer index, valid while rd_locked
//  rd_addr           out  C_ADDR_WIDTH  locked buffer base address
//  rd_locked         out  1             reader holds a buffer
//  running           out  1             state == RUN
//  frame_cnt         out  16            completed frames since reset, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; latest_valid=0; wr_started=0.
//  FSM: IDLE: soft_resetn=0; enable=1 -> RST_WAIT.
//   RST_WAIT: soft_resetn=0; s2mm_resetting=0 -> RUN (min one cycle in RST_WAIT).
//   RUN: soft_resetn=1; enable=0 -> DRAIN.
//   DRAIN: soft_resetn=0; s2mm_resetting=0 -> IDLE, clearing wr_started and latest_valid.
//  All FSM outputs are registered; s2mm_soft_resetn changes the cycle after the state change.
//  s2mm_frame_pulse is honoured in RUN only; ignored in every other state.
//  On an honoured frame_pulse (cycle N):
//   - if wr_started, the old wr_idx becomes latest, latest_valid=1, frame_cnt+1.
//   - new wr_idx = first index after old wr_idx (mod C_BUF_NUM) that is neither latest
//     (post-update) nor rd_idx when rd_locked. A candidate always exists since C_BUF_NUM>=3.
//   - wr_started=1; s2mm_base_addr=buf_addr[new wr_idx]. Both valid from cycle N+1
//     (the writer samples base_addr one cycle after frame_pulse).
//  Reader: rd_req is latched as pending. Pending and not rd_locked and latest_valid ->
//   rd_locked=1, rd_idx=latest, rd_addr=buf_addr[latest], rd_grant high for one cycle.
//   Pending with latest_valid=0 waits; pending while rd_locked is dropped (no grant).
//  rd_release clears rd_locked next cycle; rd_idx/rd_addr hold their last value.
//  Simultaneous frame_pulse + grant in one cycle: the grant takes the post-update latest, and
//   the writer selection excludes that index.
//  Simultaneous rd_release + rd_req: release applies first; the grant follows one cycle later.
//  The frame in flight at DRAIN is abandoned, not promoted. The reader lock survives
//   DRAIN/IDLE until rd_release.
//  buf_addr* are sampled only at selection/grant; later changes do not alter outputs.
// TESTING
//  1 enable=1, resetting low after 3 cycles -> soft_resetn=1 from cycle 5; running=1.
//  2 C_BUF_NUM=3, 4 frame_pulses, no reader -> wr_idx 1,2,0,1; frame_cnt 0,1,2,3;
//    s2mm_base_addr=buf_addr[wr_idx] one cycle after each pulse.
//  3 reader locks idx 0 (latest=0) while writing 1 -> next pulses wr_idx 2,1,2; never 0.
//  4 frame_pulse and rd_req in the same cycle with wr_idx=2 -> grant rd_idx=2; writer picks 0.
//  5 rd_req before any completed frame -> no grant until the 2nd frame_pulse, then rd_idx=0.
//  6 enable=0 mid-frame -> DRAIN, soft_resetn=0; on resetting low -> IDLE, latest_valid=0;
//    reassert enable -> writing resumes without promoting the abandoned buffer.

Source files
------------

// File: rtl/s2mm_frame_scheduler.sv
// -----------------------------------------------------------------------------
// s2mm_frame_scheduler
//
// Sequences and configures the S2MM frame writer. It drives the writer's
// soft_resetn through an enable/drain handshake. It rotates the writer base
// address over C_BUF_NUM (3 or 4) frame buffers. It lends the newest completed
// frame to a single reader, so that buffer cannot be overwritten while lent.
//
// Ports
//   M_AXI_ACLK        in   clock, rising edge
//   M_AXI_ARESET      in   asynchronous active-high reset
//   enable            in   software enable of the write path (level)
//   buf_addr0..3      in   buffer base addresses (buf_addr3 unused for 3 buffers)
//   s2mm_soft_resetn  out  writer soft reset, active low, registered
//   s2mm_resetting    in   writer reports it is still resetting
//   s2mm_frame_pulse  in   writer starts a new frame (one cycle)
//   s2mm_base_addr    out  base address the writer should use for the new frame
//   wr_idx            out  index of the buffer currently being written
//   rd_req            in   reader asks for the newest completed frame (pulse)
//   rd_release        in   reader returns its locked buffer (pulse)
//   rd_grant          out  one-cycle grant pulse
//   rd_idx / rd_addr  out  locked buffer index / base address
//   rd_locked         out  reader currently holds a buffer
//   running           out  FSM is in RUN
//   frame_cnt         out  completed frames since reset (wraps)
//
// C_BUF_NUM must be 3 or 4. With three buffers there is always one buffer
// that is neither the newest frame nor the reader's buffer.
// -----------------------------------------------------------------------------
module s2mm_frame_scheduler #(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_BUF_NUM    = 3,
  parameter int C_IDX_WIDTH  = 2
) (
  input  logic                    M_AXI_ACLK,
  input  logic                    M_AXI_ARESET,
  input  logic                    enable,
  input  logic [C_ADDR_WIDTH-1:0] buf_addr0,
  input  logic [C_ADDR_WIDTH-1:0] buf_addr1,
  input  logic [C_ADDR_WIDTH-1:0] buf_addr2,
  input  logic [C_ADDR_WIDTH-1:0] buf_addr3,
  output logic                    s2mm_soft_resetn,
  input  logic                    s2mm_resetting,
  input  logic                    s2mm_frame_pulse,
  output logic [C_ADDR_WIDTH-1:0] s2mm_base_addr,
  output logic [C_IDX_WIDTH-1:0]  wr_idx,
  input  logic                    rd_req,
  input  logic                    rd_release,
  output logic                    rd_grant,
  output logic [C_IDX_WIDTH-1:0]  rd_idx,
  output logic [C_ADDR_WIDTH-1:0] rd_addr,
  output logic                    rd_locked,
  output logic                    running,
  output logic [15:0]             frame_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RST_WAIT = 2'd1,
    RUN      = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic                    soft_resetn_q, soft_resetn_d;
  logic [C_IDX_WIDTH-1:0]  wr_idx_q, wr_idx_d;
  logic [C_ADDR_WIDTH-1:0] base_addr_q, base_addr_d;
  logic                    wr_started_q, wr_started_d;
  logic [C_IDX_WIDTH-1:0]  latest_q, latest_d;
  logic                    latest_valid_q, latest_valid_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;
  logic                    rd_pend_q, rd_pend_d;
  logic                    rd_locked_q, rd_locked_d;
  logic [C_IDX_WIDTH-1:0]  rd_idx_q, rd_idx_d;
  logic [C_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                    rd_grant_q, rd_grant_d;

  // Buffer address table, indexable by buffer number.
  logic [C_ADDR_WIDTH-1:0] buf_addr_arr [4];
  assign buf_addr_arr[0] = buf_addr0;
  assign buf_addr_arr[1] = buf_addr1;
  assign buf_addr_arr[2] = buf_addr2;
  assign buf_addr_arr[3] = buf_addr3;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (enable)          state_d = RST_WAIT;
      RST_WAIT: if (!s2mm_resetting) state_d = RUN;
      RUN:      if (!enable)         state_d = DRAIN;
      DRAIN:    if (!s2mm_resetting) state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // soft_resetn is derived from the current state and registered. It therefore
  // follows a state change by one cycle.
  assign soft_resetn_d = (state_q == RUN);

  // ---------------------------------------------------------------------------
  // Frame bookkeeping
  // ---------------------------------------------------------------------------
  logic                   pulse_ok;
  logic                   promote;
  logic                   drain_done;
  logic [C_IDX_WIDTH-1:0] latest_post;
  logic                   latest_valid_post;

  assign pulse_ok   = s2mm_frame_pulse && (state_q == RUN);
  // Only a frame that was actually started gets promoted. The first pulse after
  // (re)start only opens a frame.
  assign promote    = pulse_ok && wr_started_q;
  assign drain_done = (state_q == DRAIN) && !s2mm_resetting;

  // Newest completed frame as it will be after this cycle. The grant and the
  // writer selection both use this value, so a grant that coincides with a
  // frame pulse locks the frame that has just completed.
  assign latest_post       = promote ? wr_idx_q : latest_q;
  assign latest_valid_post = latest_valid_q || promote;

  // Candidate k is the (k+1)-th buffer after the current one, in rotation order.
  logic [C_IDX_WIDTH-1:0] cand_idx [C_BUF_NUM];
  logic [C_BUF_NUM-1:0]   cand_ok;

  genvar gi;
  generate
    for (gi = 0; gi < C_BUF_NUM; gi++) begin : g_cand
      assign cand_idx[gi] = C_IDX_WIDTH'((int'(wr_idx_q) + gi + 1) % C_BUF_NUM);
      // The reader's buffer stays excluded during the cycle of its release.
      // The release only takes effect on the next cycle.
      assign cand_ok[gi]  = !(latest_valid_post && (cand_idx[gi] == latest_post)) &&
                            !(rd_locked_q && (cand_idx[gi] == rd_idx_q));
    end
  endgenerate

  logic [C_IDX_WIDTH-1:0] sel_idx;
  logic                   sel_found;

  // Take the first acceptable candidate in rotation order.
  always_comb begin
    sel_idx   = wr_idx_q;
    sel_found = 1'b0;
    for (int k = 0; k < C_BUF_NUM; k++) begin
      if (!sel_found && cand_ok[k]) begin
        sel_idx   = cand_idx[k];
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    wr_idx_d       = wr_idx_q;
    base_addr_d    = base_addr_q;
    wr_started_d   = wr_started_q;
    latest_d       = latest_post;
    latest_valid_d = latest_valid_post;
    frame_cnt_d    = frame_cnt_q;

    if (pulse_ok) begin
      wr_idx_d     = sel_idx;
      base_addr_d  = buf_addr_arr[sel_idx];
      wr_started_d = 1'b1;
    end
    if (promote) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    // A frame still being written when the drain completes is abandoned.
    // The newest-frame record is also forgotten.
    if (drain_done) begin
      wr_started_d   = 1'b0;
      latest_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Reader lending
  // ---------------------------------------------------------------------------
  logic rd_pend_now;
  logic grant;

  assign rd_pend_now = rd_pend_q || rd_req;
  assign grant       = rd_pend_now && !rd_locked_q && latest_valid_post;

  always_comb begin
    rd_pend_d   = rd_pend_now;
    rd_locked_d = rd_locked_q;
    rd_idx_d    = rd_idx_q;
    rd_addr_d   = rd_addr_q;
    rd_grant_d  = grant;

    if (grant) begin
      rd_pend_d   = 1'b0;
      rd_locked_d = 1'b1;
      rd_idx_d    = latest_post;
      rd_addr_d   = buf_addr_arr[latest_post];
    end else if (rd_locked_q) begin
      // A request that arrives together with a release is kept. It is granted
      // on the next cycle, once the lock has cleared. Any other request that
      // arrives while the reader holds a buffer is discarded.
      if (rd_release) begin
        rd_locked_d = 1'b0;
      end else begin
        rd_pend_d = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_q        <= IDLE;
      soft_resetn_q  <= 1'b0;
      wr_idx_q       <= '0;
      base_addr_q    <= '0;
      wr_started_q   <= 1'b0;
      latest_q       <= '0;
      latest_valid_q <= 1'b0;
      frame_cnt_q    <= '0;
      rd_pend_q      <= 1'b0;
      rd_locked_q    <= 1'b0;
      rd_idx_q       <= '0;
      rd_addr_q      <= '0;
      rd_grant_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      soft_resetn_q  <= soft_resetn_d;
      wr_idx_q       <= wr_idx_d;
      base_addr_q    <= base_addr_d;
      wr_started_q   <= wr_started_d;
      latest_q       <= latest_d;
      latest_valid_q <= latest_valid_d;
      frame_cnt_q    <= frame_cnt_d;
      rd_pend_q      <= rd_pend_d;
      rd_locked_q    <= rd_locked_d;
      rd_idx_q       <= rd_idx_d;
      rd_addr_q      <= rd_addr_d;
      rd_grant_q     <= rd_grant_d;
    end
  end

  assign s2mm_soft_resetn = soft_resetn_q;
  assign s2mm_base_addr   = base_addr_q;
  assign wr_idx           = wr_idx_q;
  assign rd_grant         = rd_grant_q;
  assign rd_idx           = rd_idx_q;
  assign rd_addr          = rd_addr_q;
  assign rd_locked        = rd_locked_q;
  assign running          = (state_q == RUN);
  assign frame_cnt        = frame_cnt_q;

endmodule

// File: tb/tb_s2mm_frame_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for s2mm_frame_scheduler (3 buffers).
// The directed stimulus pushes the expected writer updates and reader grants
// into queues. A monitor pops one entry and compares it each time the DUT
// changes wr_idx/s2mm_base_addr or raises rd_grant. The stimulus process checks
// status signals directly.
// -----------------------------------------------------------------------------
module tb_s2mm_frame_scheduler;

  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h2000_0000;
  localparam logic [31:0] A2 = 32'h3000_0000;
  localparam logic [31:0] A3 = 32'h4000_0000;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] buf_addr0, buf_addr1, buf_addr2, buf_addr3;
  logic        s2mm_soft_resetn;
  logic        s2mm_resetting;
  logic        s2mm_frame_pulse;
  logic [31:0] s2mm_base_addr;
  logic [1:0]  wr_idx;
  logic        rd_req;
  logic        rd_release;
  logic        rd_grant;
  logic [1:0]  rd_idx;
  logic [31:0] rd_addr;
  logic        rd_locked;
  logic        running;
  logic [15:0] frame_cnt;

  s2mm_frame_scheduler #(
    .C_ADDR_WIDTH (32),
    .C_BUF_NUM    (3),
    .C_IDX_WIDTH  (2)
  ) dut (
    .M_AXI_ACLK       (clk),
    .M_AXI_ARESET     (rst),
    .enable           (enable),
    .buf_addr0        (buf_addr0),
    .buf_addr1        (buf_addr1),
    .buf_addr2        (buf_addr2),
    .buf_addr3        (buf_addr3),
    .s2mm_soft_resetn (s2mm_soft_resetn),
    .s2mm_resetting   (s2mm_resetting),
    .s2mm_frame_pulse (s2mm_frame_pulse),
    .s2mm_base_addr   (s2mm_base_addr),
    .wr_idx           (wr_idx),
    .rd_req           (rd_req),
    .rd_release       (rd_release),
    .rd_grant         (rd_grant),
    .rd_idx           (rd_idx),
    .rd_addr          (rd_addr),
    .rd_locked        (rd_locked),
    .running          (running),
    .frame_cnt        (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] addr;
    logic [15:0] cnt;
  } wr_exp_t;

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] addr;
  } gnt_exp_t;

  wr_exp_t  wq[$];
  gnt_exp_t gq[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [1:0] idx, input logic [31:0] addr, input logic [15:0] cnt);
    wr_exp_t e;
    e.idx = idx; e.addr = addr; e.cnt = cnt;
    wq.push_back(e);
  endtask

  task automatic push_gnt(input logic [1:0] idx, input logic [31:0] addr);
    gnt_exp_t e;
    e.idx = idx; e.addr = addr;
    gq.push_back(e);
  endtask

  task automatic frame_pulse();
    s2mm_frame_pulse = 1'b1;
    step();
    s2mm_frame_pulse = 1'b0;
    step(2);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares each observed writer update and each grant.
  // ---------------------------------------------------------------------------
  initial begin : monitor
    logic [1:0]  prev_wr;
    logic [31:0] prev_base;
    wait (rst == 1'b0);
    @(negedge clk);
    prev_wr   = wr_idx;
    prev_base = s2mm_base_addr;
    forever begin
      @(negedge clk);
      if (wr_idx !== prev_wr || s2mm_base_addr !== prev_base) begin
        if (wq.size() == 0) begin
          chk("unexpected_wr_update", {wr_idx, s2mm_base_addr}, {prev_wr, prev_base});
        end else begin
          wr_exp_t e;
          e = wq.pop_front();
          $display("wr  update: idx=%0d base=0x%08h cnt=%0d (exp idx=%0d base=0x%08h cnt=%0d)",
                   wr_idx, s2mm_base_addr, frame_cnt, e.idx, e.addr, e.cnt);
          chk("wr_idx", wr_idx, e.idx);
          chk("wr_base_addr", s2mm_base_addr, e.addr);
          chk("wr_frame_cnt", frame_cnt, e.cnt);
        end
        prev_wr   = wr_idx;
        prev_base = s2mm_base_addr;
      end
      if (rd_grant === 1'b1) begin
        if (gq.size() == 0) begin
          chk("unexpected_grant", rd_grant, 1'b0);
        end else begin
          gnt_exp_t g;
          g = gq.pop_front();
          $display("rd  grant : idx=%0d addr=0x%08h (exp idx=%0d addr=0x%08h)",
                   rd_idx, rd_addr, g.idx, g.addr);
          chk("grant_rd_idx", rd_idx, g.idx);
          chk("grant_rd_addr", rd_addr, g.addr);
        end
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin : stim
    rst              = 1'b1;
    enable           = 1'b0;
    buf_addr0        = A0;
    buf_addr1        = A1;
    buf_addr2        = A2;
    buf_addr3        = A3;
    s2mm_resetting   = 1'b0;
    s2mm_frame_pulse = 1'b0;
    rd_req           = 1'b0;
    rd_release       = 1'b0;
    step(3);
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_soft_resetn", s2mm_soft_resetn, 1'b0);
    chk("rst_running", running, 1'b0);
    chk("rst_wr_idx", wr_idx, 2'd0);
    chk("rst_base_addr", s2mm_base_addr, 32'd0);
    chk("rst_frame_cnt", frame_cnt, 16'd0);
    chk("rst_rd_locked", rd_locked, 1'b0);
    chk("rst_rd_grant", rd_grant, 1'b0);

    // Startup: resetting is held for 3 cycles, RUN on the 4th edge, soft_resetn on the 5th
    enable         = 1'b1;
    s2mm_resetting = 1'b1;
    step(3);
    chk("start_running_wait", running, 1'b0);
    chk("start_soft_wait", s2mm_soft_resetn, 1'b0);
    s2mm_resetting = 1'b0;
    step();
    chk("start_running", running, 1'b1);
    chk("start_soft_lag", s2mm_soft_resetn, 1'b0);
    step();
    chk("start_soft_resetn", s2mm_soft_resetn, 1'b1);

    // Plain rotation, no reader: wr_idx 1,2,0,1 ; frame_cnt 0,1,2,3
    push_wr(2'd1, A1, 16'd0); frame_pulse();
    push_wr(2'd2, A2, 16'd1); frame_pulse();
    push_wr(2'd0, A0, 16'd2); frame_pulse();
    push_wr(2'd1, A1, 16'd3); frame_pulse();

    // Reader locks latest=0 while the writer is on buffer 1
    push_gnt(2'd0, A0);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    chk("lock0_rd_grant", rd_grant, 1'b1);
    step();
    chk("lock0_grant_one_cycle", rd_grant, 1'b0);
    chk("lock0_rd_locked", rd_locked, 1'b1);
    push_wr(2'd2, A2, 16'd4); frame_pulse();
    push_wr(2'd1, A1, 16'd5); frame_pulse();
    push_wr(2'd2, A2, 16'd6); frame_pulse();
    rd_release = 1'b1;
    step();
    rd_release = 1'b0;
    chk("release_rd_locked", rd_locked, 1'b0);
    chk("release_rd_idx_hold", rd_idx, 2'd0);
    chk("release_rd_addr_hold", rd_addr, A0);

    // Frame pulse and request in the same cycle, writer on 2
    push_wr(2'd0, A0, 16'd7);
    push_gnt(2'd2, A2);
    s2mm_frame_pulse = 1'b1;
    rd_req           = 1'b1;
    step();
    s2mm_frame_pulse = 1'b0;
    rd_req           = 1'b0;
    step(2);
    chk("simul_rd_locked", rd_locked, 1'b1);

    // A request while locked is dropped, even after the later release
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    step(2);
    rd_release = 1'b1;
    step();
    rd_release = 1'b0;
    step(3);
    chk("drop_rd_locked", rd_locked, 1'b0);
    chk("drop_rd_idx_hold", rd_idx, 2'd2);

    // Lock again, then release and request together: the grant comes one cycle later
    push_gnt(2'd2, A2);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    step(2);
    push_gnt(2'd2, A2);
    rd_release = 1'b1;
    rd_req     = 1'b1;
    step();
    rd_release = 1'b0;
    rd_req     = 1'b0;
    chk("relreq_unlocked", rd_locked, 1'b0);
    chk("relreq_no_grant_yet", rd_grant, 1'b0);
    step();
    chk("relreq_grant", rd_grant, 1'b1);
    chk("relreq_relocked", rd_locked, 1'b1);
    rd_release = 1'b1;
    step();
    rd_release = 1'b0;
    step();

    // Move the writer to buffer 2 before draining
    push_wr(2'd1, A1, 16'd8); frame_pulse();
    push_wr(2'd2, A2, 16'd9); frame_pulse();

    // Drain mid-frame: pulses are ignored and the address change is not seen
    enable         = 1'b0;
    s2mm_resetting = 1'b1;
    step();
    chk("drain_running", running, 1'b0);
    chk("drain_soft_lag", s2mm_soft_resetn, 1'b1);
    step();
    chk("drain_soft_resetn", s2mm_soft_resetn, 1'b0);
    s2mm_frame_pulse = 1'b1;
    step();
    s2mm_frame_pulse = 1'b0;
    buf_addr2        = 32'hDEAD_0000;
    step(2);
    chk("drain_frame_cnt", frame_cnt, 16'd9);
    chk("drain_wr_idx", wr_idx, 2'd2);
    chk("addr_change_rd_addr", rd_addr, A2);
    chk("addr_change_base", s2mm_base_addr, A2);
    buf_addr2      = A2;
    s2mm_resetting = 1'b0;
    step();
    chk("idle_running", running, 1'b0);
    step();

    // Re-enable
    enable         = 1'b1;
    s2mm_resetting = 1'b1;
    step(2);
    s2mm_resetting = 1'b0;
    step(2);
    chk("resume_running", running, 1'b1);
    chk("resume_soft_resetn", s2mm_soft_resetn, 1'b1);

    // Request before any completed frame: granted at the 2nd pulse with rd_idx=0.
    // The abandoned buffer 2 is not promoted.
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    step(2);
    chk("pend_no_lock", rd_locked, 1'b0);
    push_wr(2'd0, A0, 16'd9); frame_pulse();
    chk("pend_no_lock_after_1st", rd_locked, 1'b0);
    push_wr(2'd1, A1, 16'd10);
    push_gnt(2'd0, A0);
    frame_pulse();
    chk("pend_locked", rd_locked, 1'b1);
    chk("pend_rd_idx", rd_idx, 2'd0);

    step(3);
    chk("wr_queue_drained", wq.size(), 0);
    chk("gnt_queue_drained", gq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
